// File: rtl/simon_playback_sequencer_if.sv
// Playback bus between the Simon game controller, the pattern register file and the sequencer.
interface simon_playback_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int PAT_W  = 4
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] last;
  logic [PAT_W-1:0]  rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [PAT_W-1:0]  pattern_leds;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, last, rd_data,
    input  rd_addr, pattern_leds, busy, done
  );

  modport slave (
    input  start, abort, last, rd_data,
    output rd_addr, pattern_leds, busy, done
  );
endinterface

// File: rtl/simon_playback_sequencer.sv
// Timed Simon playback: walks the pattern register file 0..last, showing each entry for ON_CYCLES
// then blanking for OFF_CYCLES. The blank gap is only built when SIMON_PLAYBACK_GAP_EN is defined.
module simon_playback_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int PAT_W      = 4,
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  simon_playback_sequencer_if.slave bus
);
  localparam int MAX_C = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHOW  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W-1:0] last_q, last_n;
  logic [PAT_W-1:0]  leds, leds_n;
  logic              busy, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr   <= '0;
      last_q <= '0;
      leds   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr   <= addr_n;
      last_q <= last_n;
      leds   <= leds_n;
      busy   <= (state_n != IDLE);
      done   <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    last_n  = last_q;
    leds_n  = leds;
    case (state)
      IDLE: begin
        leds_n = '0;
        if (bus.start && !bus.abort) begin
          last_n  = bus.last;
          addr_n  = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        leds_n  = bus.rd_data;
        cnt_n   = CW'(ON_CYCLES - 1);
        state_n = SHOW;
      end
      SHOW: begin
        if (cnt == '0) begin
          leds_n = '0;
`ifdef SIMON_PLAYBACK_GAP_EN
          cnt_n   = CW'(OFF_CYCLES - 1);
          state_n = GAP;
`else
          // no gap: step straight to the next fetch; compare before incrementing so addr never wraps
          if (addr == last_q) state_n = DONE;
          else begin
            addr_n  = addr + 1'b1;
            state_n = FETCH;
          end
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef SIMON_PLAYBACK_GAP_EN
      GAP: begin
        leds_n = '0;
        if (cnt == '0) begin
          if (addr == last_q) state_n = DONE;
          else begin
            addr_n  = addr + 1'b1;
            state_n = FETCH;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      DONE: begin
        leds_n  = '0;
        state_n = IDLE;
      end
      default: begin
        leds_n  = '0;
        state_n = IDLE;
      end
    endcase
    // abort leaves rd_addr where it was so the controller can see how far playback got
    if (bus.abort && state != IDLE) begin
      state_n = IDLE;
      leds_n  = '0;
      addr_n  = addr;
    end
  end

  assign bus.rd_addr      = addr;
  assign bus.pattern_leds = leds;
  assign bus.busy         = busy;
  assign bus.done         = done;
endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Scoreboarded bench: stimulus pushes per-cycle expected outputs derived from the playback timing rules.
module tb_simon_playback_sequencer;
  localparam int ADDR_W = 6;
  localparam int PAT_W  = 4;
  localparam int ON     = 8;
  localparam int OFF    = 4;
`ifdef SIMON_PLAYBACK_GAP_EN
  localparam int GAPC = OFF;
`else
  localparam int GAPC = 0;
`endif
  localparam int P = 1 + ON + GAPC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  simon_playback_sequencer_if #(.ADDR_W(ADDR_W), .PAT_W(PAT_W)) bus ();

  simon_playback_sequencer #(
    .ADDR_W(ADDR_W), .PAT_W(PAT_W), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [PAT_W-1:0] mem [0:(1<<ADDR_W)-1];
  assign bus.rd_data = mem[bus.rd_addr];

  typedef struct {
    int                cyc;
    logic [PAT_W-1:0]  leds;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
  } rec_t;

  rec_t q[$];
  int cyc = 0;
  int vectors = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_rec(int c, logic [PAT_W-1:0] l, logic b, logic d, logic [ADDR_W-1:0] a);
    rec_t r;
    r.cyc = c; r.leds = l; r.busy = b; r.done = d; r.addr = a;
    q.push_back(r);
  endfunction

  function automatic logic busy_at(int c);
    foreach (q[i]) if (q[i].cyc == c) return q[i].busy;
    return 1'b0;
  endfunction

  // Expected trace of one playback accepted at the edge ending cycle t.
  function automatic void push_play(int t, logic [ADDR_W-1:0] l);
    int c = t + 1;
    for (int i = 0; i <= int'(l); i++) begin
      push_rec(c, '0, 1'b1, 1'b0, ADDR_W'(i)); c++;
      for (int k = 0; k < ON; k++) begin push_rec(c, mem[i], 1'b1, 1'b0, ADDR_W'(i)); c++; end
      for (int k = 0; k < GAPC; k++) begin push_rec(c, '0, 1'b1, 1'b0, ADDR_W'(i)); c++; end
    end
    push_rec(c, '0, 1'b1, 1'b1, l);
    push_rec(c + 1, '0, 1'b0, 1'b0, l);
  endfunction

  function automatic void model_abort(int a);
    logic [ADDR_W-1:0] ad;
    bit hit = 0;
    foreach (q[i]) if (q[i].cyc == a && q[i].busy) begin hit = 1; ad = q[i].addr; end
    if (hit) begin
      while (q.size() > 0 && q[q.size()-1].cyc > a) void'(q.pop_back());
      push_rec(a + 1, '0, 1'b0, 1'b0, ad);
    end
  endfunction

  function automatic void check(string nm, logic [PAT_W-1:0] el, logic eb, logic ed,
                                logic [ADDR_W-1:0] ea, bit chk_addr);
    vectors++;
    if (bus.pattern_leds !== el || bus.busy !== eb || bus.done !== ed ||
        (chk_addr && bus.rd_addr !== ea)) begin
      errors++;
      $display("FAIL %s cyc=%0d got leds=%h busy=%b done=%b addr=%0d, expected leds=%h busy=%b done=%b addr=%0d",
               nm, cyc, bus.pattern_leds, bus.busy, bus.done, bus.rd_addr, el, eb, ed, ea);
    end
  endfunction

  // Monitor: compare against the expected record for this cycle, otherwise expect quiet idle.
  always @(negedge clk) begin
    rec_t r;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      vectors++; errors++;
      $display("FAIL stale_expect cyc=%0d got no check, expected record for cyc=%0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      r = q.pop_front();
      check("playback", r.leds, r.busy, r.done, r.addr, 1'b1);
    end else begin
      check("idle", '0, 1'b0, 1'b0, '0, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(bit s, bit a, logic [ADDR_W-1:0] l);
    bus.start = s; bus.abort = a; bus.last = l;
    if (a) model_abort(cyc);
    else if (s && !busy_at(cyc)) push_play(cyc, l);
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin tick(); n++; end
    if (q.size() > 0) begin
      vectors++; errors++;
      $display("FAIL wait_idle timeout cyc=%0d got %0d pending, expected 0", cyc, q.size());
      q.delete();
    end
  endtask

  task automatic wait_post_done(int budget);
    int n = 0;
    while (!(q.size() > 0 && q[0].cyc == cyc && !q[0].busy) && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      vectors++; errors++;
      $display("FAIL wait_post_done timeout cyc=%0d got busy=%b, expected post-done idle", cyc, bus.busy);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = PAT_W'($urandom_range(1, (1<<PAT_W)-1));
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.last = '0;
    rand_mem();
    #1 rst_n = 1'b0;
    #1;
    check("reset", '0, 1'b0, 1'b0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) tick();

    // directed: three-entry playback
    mem[0] = 4'h1; mem[1] = 4'h8; mem[2] = 4'h3;
    drive(1, 0, 6'd2);
    wait_idle(3*P + 10);

    // single entry
    mem[0] = 4'hF;
    drive(1, 0, 6'd0);
    wait_idle(P + 10);

    // abort during the second SHOW, then replay from 0
    rand_mem();
    drive(1, 0, 6'd3);
    repeat (P + 4) tick();
    drive(0, 1, 6'd0);
    wait_idle(10);
    drive(1, 0, 6'd1);
    wait_idle(2*P + 10);

    // start+abort together while idle; start pulsed while busy
    drive(1, 1, 6'd4);
    repeat (3) tick();
    drive(1, 0, 6'd2);
    repeat (5) tick();
    drive(1, 0, 6'd7);
    repeat (P) tick();
    drive(1, 0, 6'd0);
    wait_post_done(3*P + 10);
    // back-to-back start in the IDLE cycle following DONE
    drive(1, 0, 6'd1);
    wait_idle(2*P + 10);

    // randomized runs with optional aborts and stray starts
    for (int n = 0; n < 14; n++) begin
      logic [ADDR_W-1:0] l;
      rand_mem();
      l = ADDR_W'($urandom_range(0, 5));
      repeat ($urandom_range(0, 3)) tick();
      drive(1, 0, l);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, (int'(l)+1)*P)) tick();
        drive($urandom_range(0, 1) == 1, 1, ADDR_W'($urandom));
      end else if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, P)) tick();
        drive(1, 0, ADDR_W'($urandom));
      end
      wait_idle(7*P + 10);
    end

    // asynchronous reset mid-SHOW, then full 64-entry playback
    drive(1, 0, 6'd5);
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", '0, 1'b0, 1'b0, '0, 1'b1);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    rand_mem();
    drive(1, 0, 6'd63);
    wait_idle(64*P + 20);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
